uart_tx: RTL and testbench

Serial transmitter for the interchange test designs. It accepts a parallel byte over a valid/ready handshake and shifts it out as an asynchronous serial frame: start bit, data LSB-first, optional parity, then stop bits. Its `tx` output drives an output-buffer pad. It is the transmit-side counterpart to the input-pad serial receivers used in the loopback tests.

---
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: parallel-to-serial transmitter (start, LSB-first data, stop bits), tx idles high.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_done;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif
    logic                 w_bit_end;
    logic                 w_accept;

    assign w_bit_end = (r_cnt == CNT_MAX);
    assign w_accept  = tx_valid && r_ready;

    // r_idx counts data bits in DATA and stop bits in STOP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_cnt  <= (r_state == IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_idx   <= '0;
                    if (w_accept) begin
                        r_shift  <= tx_data;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^tx_data;
`endif
                        r_tx     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_idx   <= '0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == DATA_LAST) begin
                            r_idx   <= '0;
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_idx   <= '0;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        if (r_idx == STOP_LAST) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            r_tx    <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx         = r_tx;
    assign tx_ready   = r_ready;
    assign frame_done = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with CLKS_PER_BIT=4, DATA_BITS=8,
// one instance with one stop bit (sel 0) and one with two stop bits (sel 1).
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       valid0, valid1;
    logic       tx0, rdy0, done0;
    logic       tx1, rdy1, done1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid0),
        .tx_ready(rdy0), .tx(tx0), .frame_done(done0)
    );
    uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid1),
        .tx_ready(rdy1), .tx(tx1), .frame_done(done1)
    );

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       par;
        int         f_nopar;
    } vec_t;

    function automatic logic tx_of(int sel);
        return sel != 0 ? tx1 : tx0;
    endfunction
    function automatic logic rdy_of(int sel);
        return sel != 0 ? rdy1 : rdy0;
    endfunction
    function automatic logic done_of(int sel);
        return sel != 0 ? done1 : done0;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) valid1 = v;
        else valid0 = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one frame starting at the current negedge and checks every cycle of it.
    task automatic run_frame(input int sel, input logic [7:0] d, input logic par,
                             input int f_nopar, input bit hold, input logic [7:0] nd,
                             input string name, output int waited);
        int f;
        int b;
        logic e;
        f = f_nopar + C * P;
        waited = 0;
        while (!rdy_of(sel) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            chk({name, " ready_timeout"}, 0, 1);
            return;
        end
        tx_data = d;
        set_valid(sel, 1'b1);
        @(posedge clk);
        for (int j = 0; j < f; j++) begin
            @(negedge clk);
            if (j == 0) begin
                if (!hold) set_valid(sel, 1'b0);
                tx_data = nd;
            end
            b = j / C;
            e = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : (P == 1 && b == 9) ? par : 1'b1;
            chk($sformatf("%s tx c%0d", name, j), tx_of(sel), e);
            chk($sformatf("%s ready c%0d", name, j), rdy_of(sel), 0);
            chk($sformatf("%s done c%0d", name, j), done_of(sel), 0);
        end
        @(negedge clk);
        chk({name, " done_end"}, done_of(sel), 1);
        chk({name, " ready_end"}, rdy_of(sel), 1);
        chk({name, " tx_end"}, tx_of(sel), 1);
    endtask

    initial begin
        vec_t vecs[4];
        int w, w2;
        vecs[0] = '{sel: 0, d: 8'hA5, par: 1'b0, f_nopar: 40};
        vecs[1] = '{sel: 0, d: 8'h01, par: 1'b1, f_nopar: 40};
        vecs[2] = '{sel: 1, d: 8'h3C, par: 1'b0, f_nopar: 44};
        vecs[3] = '{sel: 1, d: 8'hA5, par: 1'b0, f_nopar: 44};

        rst_n = 1'b0;
        valid0 = 1'b1;
        valid1 = 1'b1;
        tx_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst tx c%0d", i), {tx1, tx0}, 2'b11);
            chk($sformatf("rst ready c%0d", i), {rdy1, rdy0}, 2'b00);
            chk($sformatf("rst done c%0d", i), {done1, done0}, 2'b00);
        end
        rst_n = 1'b1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        @(negedge clk);
        chk("post_rst ready", {rdy1, rdy0}, 2'b11);
        chk("post_rst tx", {tx1, tx0}, 2'b11);
        chk("post_rst done", {done1, done0}, 2'b00);

        for (int i = 0; i < 4; i++)
            run_frame(vecs[i].sel, vecs[i].d, vecs[i].par, vecs[i].f_nopar, 1'b0,
                      ~vecs[i].d, $sformatf("vec%0d", i), w);

        // Back-to-back: valid stays high, data switches to 0xFF during the first frame.
        run_frame(0, 8'h00, 1'b0, 40, 1'b1, 8'hFF, "b2b0", w);
        run_frame(0, 8'hFF, 1'b0, 40, 1'b0, 8'hFF, "b2b1", w2);
        chk("b2b second_accept_wait", w2, 0);

        // Reset during data bit 3 of 0x55.
        tx_data = 8'h55;
        valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        repeat (17) @(negedge clk);
        chk("midrst bit3 before", tx0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst tx", tx0, 1);
        chk("midrst ready", rdy0, 0);
        chk("midrst done", done0, 0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst hold tx", tx0, 1);
            chk("midrst hold done", done0, 0);
        end
        rst_n = 1'b1;
        run_frame(0, 8'h81, 1'b0, 40, 1'b0, 8'h00, "after_rst", w);
        chk("after_rst wait", w, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
